dpram_port_arbiter: RTL

Shares the 8x16 asynchronous dual-port RAM (ports A/B: we, addr, din, dout) between NUM_REQ requesters. Each cycle, a round-robin scheduler grants up to two pending requests, one per RAM port, and serializes same-address hazards. After reset, an init sequencer clears all RAM entries before any requester is served. Sits between client logic and the RAM; it is the only driver of the RAM port inputs.

---
 rtl/dpram_port_arbiter_pkg.sv | 27 ++
 rtl/dpram_port_arbiter_if.sv | 26 ++
 rtl/dpram_rr_pick.sv | 40 ++++
 rtl/dpram_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_port_arbiter_pkg.sv
// Shared constants, types and helpers for the dual-port RAM arbiter.
package dpram_arb_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  // Arbiter phases: clear the RAM, let the last clear write settle, then serve.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } arb_state_t;

  // Registered controls for one RAM port.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } port_ctrl_t;

  // Increment an index and wrap it back to zero at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bus of the arbiter: requests in, grants and read data out.
interface dpram_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 16
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [NUM_REQ*DATA_W-1:0] rdata;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dpram_rr_pick.sv
// Round-robin picker: finds the first and second pending requesters,
// scanning upward from ptr and wrapping around. Purely combinational.
module dpram_rr_pick
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   first_idx,
  output logic               first_vld,
  output logic [IDX_W-1:0]   second_idx,
  output logic               second_vld
);

  int scan_idx;

  // Walk all requesters once from ptr, keeping the first two that are pending.
  always_comb begin
    first_idx  = '0;
    first_vld  = 1'b0;
    second_idx = '0;
    second_vld = 1'b0;
    scan_idx   = int'(ptr);
    for (int off = 0; off < NUM_REQ; off++) begin
      if (pending[scan_idx]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = IDX_W'(scan_idx);
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_idx = IDX_W'(scan_idx);
        end
      end
      scan_idx = wrap_inc(scan_idx, NUM_REQ);
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Arbiter that shares an 8x16 asynchronous dual-port RAM between NUM_REQ
// requesters. After reset it clears every RAM entry, then grants up to two
// requests per cycle (P0 on port A, P1 on port B) in round-robin order,
// holding back P1 when it hits the same address as P0 and either one writes.
// Optional feature macro: DPRAM_ARB_CONFLICT_CNT_EN adds a saturating
// conflict_cnt output counting cycles in which P1 was held back.
module dpram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = dpram_arb_pkg::ADDR_W,
  parameter int DATA_W  = dpram_arb_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpram_port_arbiter_if.slave  bus,
  output logic                 init_done,
  output logic                 we_a,
  output logic [ADDR_W-1:0]    addr_a,
  output logic [DATA_W-1:0]    din_a,
  input  logic [DATA_W-1:0]    dout_a,
  output logic                 we_b,
  output logic [ADDR_W-1:0]    addr_b,
  output logic [DATA_W-1:0]    din_b,
  input  logic [DATA_W-1:0]    dout_b
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]          conflict_cnt
`endif
);

  import dpram_arb_pkg::*;

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int INIT_W = $clog2(DEPTH / 2);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEPTH / 2 - 1);

  arb_state_t                state_q, state_d;
  logic [INIT_W-1:0]         init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  port_ctrl_t                port_a_q, port_a_d;
  port_ctrl_t                port_b_q, port_b_d;
  logic                      a_rd_q, a_rd_d;
  logic                      b_rd_q, b_rd_d;
  logic [IDX_W-1:0]          a_idx_q, a_idx_d;
  logic [IDX_W-1:0]          b_idx_q, b_idx_d;
  logic [NUM_REQ-1:0]        rvalid_q, rvalid_d;
  logic [NUM_REQ*DATA_W-1:0] rdata_q, rdata_d;
  logic                      init_done_q, init_done_d;

  logic [NUM_REQ-1:0]        pending;
  logic [IDX_W-1:0]          p0_idx, p1_idx;
  logic                      p0_vld, p1_vld;
  logic                      p0_we, p1_we;
  logic [ADDR_W-1:0]         p0_addr, p1_addr;
  logic [DATA_W-1:0]         p0_wdata, p1_wdata;
  logic                      hazard;
  logic                      grant_b;
  logic [NUM_REQ-1:0]        gnt_vec;

  // Requests are only visible to the scheduler once the RAM has been cleared.
  assign pending = (state_q == RUN) ? bus.req : '0;

  dpram_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pending    (pending),
    .ptr        (rr_ptr_q),
    .first_idx  (p0_idx),
    .first_vld  (p0_vld),
    .second_idx (p1_idx),
    .second_vld (p1_vld)
  );

  assign p0_we    = bus.req_we[p0_idx];
  assign p1_we    = bus.req_we[p1_idx];
  assign p0_addr  = bus.req_addr[p0_idx*ADDR_W +: ADDR_W];
  assign p1_addr  = bus.req_addr[p1_idx*ADDR_W +: ADDR_W];
  assign p0_wdata = bus.req_wdata[p0_idx*DATA_W +: DATA_W];
  assign p1_wdata = bus.req_wdata[p1_idx*DATA_W +: DATA_W];

  // Same address with any write involved would race inside the RAM, so P1 waits.
  assign hazard  = p0_vld && p1_vld && (p0_addr == p1_addr) && (p0_we || p1_we);
  assign grant_b = p1_vld && !hazard;

  // Grant pulses follow the scheduler decision in the same cycle.
  always_comb begin
    gnt_vec = '0;
    if (p0_vld) begin
      gnt_vec[p0_idx] = 1'b1;
    end
    if (grant_b) begin
      gnt_vec[p1_idx] = 1'b1;
    end
  end

  // Phase sequencing, RAM port register loading and round-robin pointer advance.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    port_a_d    = port_a_q;
    port_b_d    = port_b_q;
    port_a_d.we = 1'b0;
    port_b_d.we = 1'b0;
    a_rd_d      = 1'b0;
    b_rd_d      = 1'b0;
    a_idx_d     = p0_idx;
    b_idx_d     = p1_idx;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        port_a_d.we   = 1'b1;
        port_a_d.addr = {init_cnt_q, 1'b0};
        port_a_d.din  = '0;
        port_b_d.we   = 1'b1;
        port_b_d.addr = {init_cnt_q, 1'b1};
        port_b_d.din  = '0;
        init_cnt_d    = init_cnt_q + 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        init_done_d = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (p0_vld) begin
          port_a_d.we   = p0_we;
          port_a_d.addr = p0_addr;
          port_a_d.din  = p0_wdata;
          a_rd_d        = !p0_we;
        end
        if (grant_b) begin
          port_b_d.we   = p1_we;
          port_b_d.addr = p1_addr;
          port_b_d.din  = p1_wdata;
          b_rd_d        = !p1_we;
        end
        if (grant_b) begin
          rr_ptr_d = IDX_W'(wrap_inc(int'(p1_idx), NUM_REQ));
        end else if (p0_vld) begin
          rr_ptr_d = IDX_W'(wrap_inc(int'(p0_idx), NUM_REQ));
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Capture RAM read data one cycle after the port registers were loaded.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (a_rd_q) begin
      rvalid_d[a_idx_q]                  = 1'b1;
      rdata_d[a_idx_q*DATA_W +: DATA_W]  = dout_a;
    end
    if (b_rd_q) begin
      rvalid_d[b_idx_q]                  = 1'b1;
      rdata_d[b_idx_q*DATA_W +: DATA_W]  = dout_b;
    end
  end

  // State registers; reset drops any in-flight read and restarts the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      port_a_q    <= '0;
      port_b_q    <= '0;
      a_rd_q      <= 1'b0;
      b_rd_q      <= 1'b0;
      a_idx_q     <= '0;
      b_idx_q     <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      port_a_q    <= port_a_d;
      port_b_q    <= port_b_d;
      a_rd_q      <= a_rd_d;
      b_rd_q      <= b_rd_d;
      a_idx_q     <= a_idx_d;
      b_idx_q     <= b_idx_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Count cycles where P1 was held back by the address hazard, saturating.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (hazard && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

  assign bus.gnt    = gnt_vec;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign init_done  = init_done_q;
  assign we_a       = port_a_q.we;
  assign addr_a     = port_a_q.addr;
  assign din_a      = port_a_q.din;
  assign we_b       = port_b_q.we;
  assign addr_b     = port_b_q.addr;
  assign din_b      = port_b_q.din;

endmodule
